// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, result {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   dvd_reg, dvd_next;
  logic [WIDTH-1:0]   dvs_reg, dvs_next;
  logic               sign1_reg, sign1_next;
  logic               sign2_reg, sign2_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] result_reg, result_next;
  logic               div_zero_reg, div_zero_next;

  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   diff, iter_rem, iter_dvd, q_fix, r_fix;

  // Operand magnitudes at acceptance; the most-negative value maps to 2^(WIDTH-1) unsigned.
  assign op1_neg = signed_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_i & opdata2_i[WIDTH-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

  // One restoring step; the shifted remainder needs WIDTH+1 bits, the difference fits in WIDTH.
  assign shifted  = {rem_reg, dvd_reg[WIDTH-1]};
  assign ge       = shifted >= {1'b0, dvs_reg};
  assign diff     = shifted[WIDTH-1:0] - dvs_reg;
  assign iter_rem = ge ? diff : shifted[WIDTH-1:0];
  assign iter_dvd = {dvd_reg[WIDTH-2:0], ge};
  assign q_fix    = (sign1_reg ^ sign2_reg) ? -iter_dvd : iter_dvd;
  assign r_fix    = sign1_reg ? -iter_rem : iter_rem;

  always_comb begin
    state_next    = state_reg;
    rem_next      = rem_reg;
    dvd_next      = dvd_reg;
    dvs_next      = dvs_reg;
    sign1_next    = sign1_reg;
    sign2_next    = sign2_reg;
    cnt_next      = cnt_reg;
    result_next   = result_reg;
    div_zero_next = div_zero_reg;
    ready_o       = (state_reg == DONE);
    busy_o        = (state_reg == BUSY);
    result_o      = result_reg;
    div_zero_o    = div_zero_reg;

    case (state_reg)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_next    = DONE;
            result_next   = {opdata1_i, {WIDTH{1'b1}}};
            div_zero_next = 1'b1;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (op1_mag < op2_mag) begin
            state_next  = DONE;
            result_next = {opdata1_i, {WIDTH{1'b0}}};
          end
`endif
          else begin
            state_next = BUSY;
            rem_next   = '0;
            dvd_next   = op1_mag;
            dvs_next   = op2_mag;
            sign1_next = op1_neg;
            sign2_next = op2_neg;
            cnt_next   = '0;
          end
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_next = IDLE;
        end else begin
          rem_next = iter_rem;
          dvd_next = iter_dvd;
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == CW'(WIDTH - 1)) begin
            state_next  = DONE;
            result_next = {r_fix, q_fix};
          end
        end
      end
      DONE: begin
        state_next    = IDLE;
        div_zero_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rem_reg      <= '0;
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      sign1_reg    <= 1'b0;
      sign2_reg    <= 1'b0;
      cnt_reg      <= '0;
      result_reg   <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rem_reg      <= rem_next;
      dvd_reg      <= dvd_next;
      dvs_reg      <= dvs_next;
      sign1_reg    <= sign1_next;
      sign2_reg    <= sign2_next;
      cnt_reg      <= cnt_next;
      result_reg   <= result_next;
      div_zero_reg <= div_zero_next;
    end
  end

endmodule
